// File: rtl/pc_source_reg.sv
// ---------------------------------------------------------------------------
// pc_source_reg
//
// Registered next-PC selector for the multicycle CPU datapath. One of N_SRC
// candidate next-PC buses is picked by pc_sel and loaded into the PC register
// when the control unit requests an unconditional load (pc_write) or a taken
// branch (pc_write_cond & cond). Targets are screened before they are
// accepted: a select beyond the populated sources or (optionally) a
// non-word-aligned target diverts to EXC_VECTOR instead, as does an external
// exception request. The block then parks in TRAP, with epc/exc_cause
// describing the event, until the control unit acknowledges.
//
// Ports
//   clk           in   1             rising-edge clock
//   reset_n       in   1             asynchronous active-low reset
//   src_bus       in   N_SRC*DATA_W  source i at bits [i*DATA_W +: DATA_W]
//   pc_sel        in   SEL_W         source index
//   pc_write      in   1             unconditional load request
//   pc_write_cond in   1             conditional load request
//   cond          in   1             branch condition qualifying pc_write_cond
//   exc_req       in   1             external exception request
//   exc_ack       in   1             trap handling finished
//   pc            out  DATA_W        current PC register
//   epc           out  DATA_W        PC captured at exception entry
//   exc_cause     out  2             0 none, 1 external, 2 misaligned, 3 illegal select
//   pc_valid      out  1             high while in RUN
//   load_cnt      out  16            successful PC loads, wrapping
//
// All outputs come straight from flops; there is no input-to-output path.
// ---------------------------------------------------------------------------
module pc_source_reg #(
   parameter int                DATA_W      = 32,
   parameter int                N_SRC       = 6,
   parameter int                SEL_W       = 3,
   parameter logic [DATA_W-1:0] RESET_PC    = 32'h0000_0000,
   parameter logic [DATA_W-1:0] EXC_VECTOR  = 32'h0000_00FC,
   parameter int                ALIGN_CHECK = 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [N_SRC*DATA_W-1:0] src_bus,
   input  logic [SEL_W-1:0]        pc_sel,
   input  logic                    pc_write,
   input  logic                    pc_write_cond,
   input  logic                    cond,
   input  logic                    exc_req,
   input  logic                    exc_ack,
   output logic [DATA_W-1:0]       pc,
   output logic [DATA_W-1:0]       epc,
   output logic [1:0]              exc_cause,
   output logic                    pc_valid,
   output logic [15:0]             load_cnt
);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_TRAP = 2'd2
   } state_t;

   localparam logic [1:0] CAUSE_NONE  = 2'd0;
   localparam logic [1:0] CAUSE_EXT   = 2'd1;
   localparam logic [1:0] CAUSE_ALIGN = 2'd2;
   localparam logic [1:0] CAUSE_SEL   = 2'd3;

   // Architectural state
   state_t              state_r;
   logic [DATA_W-1:0]   pc_r;
   logic [DATA_W-1:0]   epc_r;
   logic [1:0]          cause_r;
   logic                valid_r;
   logic [15:0]         cnt_r;

   // Next-state values
   state_t              state_nxt_s;
   logic [DATA_W-1:0]   pc_nxt_s;
   logic [DATA_W-1:0]   epc_nxt_s;
   logic [1:0]          cause_nxt_s;
   logic [15:0]         cnt_nxt_s;

   // Target screening
   logic [DATA_W-1:0]   target_s;
   logic                ld_s;
   logic                illegal_s;
   logic                misalign_s;

   // A taken conditional and an unconditional request in the same cycle
   // collapse into a single load.
   assign ld_s = pc_write | (pc_write_cond & cond);

   // Source multiplexer: walk only the populated slices so an out-of-range
   // select never indexes past src_bus (it yields zero and is trapped below).
   always_comb begin
      target_s = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (pc_sel == SEL_W'(i)) begin
            target_s = src_bus[i*DATA_W +: DATA_W];
         end else begin
            target_s = target_s;
         end
      end
   end

   // Illegal-select detection only exists when the select space is larger
   // than the populated sources; otherwise it is a constant zero.
   generate
      if (N_SRC < (2**SEL_W)) begin : g_sel_chk
         localparam logic [SEL_W:0] N_SRC_L = (SEL_W+1)'(N_SRC);
         assign illegal_s = ({1'b0, pc_sel} >= N_SRC_L);
      end else begin : g_no_sel_chk
         assign illegal_s = 1'b0;
      end
   endgenerate

   // Word-alignment screening of the selected target.
   generate
      if (ALIGN_CHECK != 0) begin : g_align_chk
         assign misalign_s = (target_s[1:0] != 2'b00);
      end else begin : g_no_align_chk
         assign misalign_s = 1'b0;
      end
   endgenerate

   // Next-state and datapath update: BOOT/RUN/TRAP sequencing with the
   // exception > illegal select > misaligned > load priority in RUN.
   always_comb begin
      state_nxt_s = state_r;
      pc_nxt_s    = pc_r;
      epc_nxt_s   = epc_r;
      cause_nxt_s = cause_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         ST_BOOT: begin
            // Single settling cycle; every request is ignored.
            state_nxt_s = ST_RUN;
         end
         ST_RUN: begin
            if (exc_req) begin
               // Same-cycle load requests are discarded.
               epc_nxt_s   = pc_r;
               cause_nxt_s = CAUSE_EXT;
               pc_nxt_s    = EXC_VECTOR;
               state_nxt_s = ST_TRAP;
            end else if (ld_s && illegal_s) begin
               epc_nxt_s   = pc_r;
               cause_nxt_s = CAUSE_SEL;
               pc_nxt_s    = EXC_VECTOR;
               state_nxt_s = ST_TRAP;
            end else if (ld_s && misalign_s) begin
               epc_nxt_s   = pc_r;
               cause_nxt_s = CAUSE_ALIGN;
               pc_nxt_s    = EXC_VECTOR;
               state_nxt_s = ST_TRAP;
            end else if (ld_s) begin
               pc_nxt_s    = target_s;
               cnt_nxt_s   = cnt_r + 16'd1;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_TRAP: begin
            if (exc_ack && pc_write) begin
               // Return with a new PC. A bad target re-traps in place: the
               // cause is updated but epc keeps the original trap PC.
               if (illegal_s) begin
                  cause_nxt_s = CAUSE_SEL;
                  pc_nxt_s    = EXC_VECTOR;
               end else if (misalign_s) begin
                  cause_nxt_s = CAUSE_ALIGN;
                  pc_nxt_s    = EXC_VECTOR;
               end else begin
                  pc_nxt_s    = target_s;
                  cnt_nxt_s   = cnt_r + 16'd1;
                  cause_nxt_s = CAUSE_NONE;
                  state_nxt_s = ST_RUN;
               end
            end else if (exc_ack) begin
               cause_nxt_s = CAUSE_NONE;
               state_nxt_s = ST_RUN;
            end else begin
               // Loads and nested exception requests are dropped here.
               state_nxt_s = ST_TRAP;
            end
         end
         default: begin
            // Unreachable encoding: fall back to the reset picture.
            state_nxt_s = ST_BOOT;
            pc_nxt_s    = RESET_PC;
            epc_nxt_s   = '0;
            cause_nxt_s = CAUSE_NONE;
            cnt_nxt_s   = 16'd0;
         end
      endcase
   end

   // State and output registers; pc_valid is registered from the next state
   // so it rises together with entry into RUN.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_BOOT;
         pc_r    <= RESET_PC;
         epc_r   <= '0;
         cause_r <= CAUSE_NONE;
         valid_r <= 1'b0;
         cnt_r   <= 16'd0;
      end else begin
         state_r <= state_nxt_s;
         pc_r    <= pc_nxt_s;
         epc_r   <= epc_nxt_s;
         cause_r <= cause_nxt_s;
         valid_r <= (state_nxt_s == ST_RUN);
         cnt_r   <= cnt_nxt_s;
      end
   end

   assign pc        = pc_r;
   assign epc       = epc_r;
   assign exc_cause = cause_r;
   assign pc_valid  = valid_r;
   assign load_cnt  = cnt_r;

endmodule

// File: tb/tb_pc_source_reg.sv
// ---------------------------------------------------------------------------
// tb_pc_source_reg
//
// Scoreboard bench for pc_source_reg with default parameters (6 sources of
// 32 bits, 3-bit select). Each scenario task drives a short table of
// requests, pushes the expected register picture when it drives, and pops
// and compares it once the DUT has clocked.
// ---------------------------------------------------------------------------
module tb_pc_source_reg;

   localparam int DATA_W = 32;
   localparam int N_SRC  = 6;
   localparam int SEL_W  = 3;

   // ctl = {pc_write, pc_write_cond, cond, exc_req, exc_ack}
   typedef struct packed {
      logic [4:0] ctl;
      logic [2:0] sel;
   } stim_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] epc;
      logic [1:0]  cause;
      logic        valid;
      logic [15:0] cnt;
   } snap_t;

   logic                    clk = 1'b0;
   logic                    reset_n;
   logic [N_SRC*DATA_W-1:0] src_bus;
   logic [SEL_W-1:0]        pc_sel;
   logic                    pc_write;
   logic                    pc_write_cond;
   logic                    cond;
   logic                    exc_req;
   logic                    exc_ack;
   logic [DATA_W-1:0]       pc;
   logic [DATA_W-1:0]       epc;
   logic [1:0]              exc_cause;
   logic                    pc_valid;
   logic [15:0]             load_cnt;

   int    checks   = 0;
   int    failures = 0;
   snap_t exp_q[$];

   pc_source_reg dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .src_bus       (src_bus),
      .pc_sel        (pc_sel),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .cond          (cond),
      .exc_req       (exc_req),
      .exc_ack       (exc_ack),
      .pc            (pc),
      .epc           (epc),
      .exc_cause     (exc_cause),
      .pc_valid      (pc_valid),
      .load_cnt      (load_cnt)
   );

   always #5 clk = ~clk;

   function automatic stim_t mk_stim(input logic [4:0] ctl, input logic [2:0] sel);
      stim_t s;
      s.ctl = ctl;
      s.sel = sel;
      return s;
   endfunction

   function automatic snap_t mk_snap(input logic [31:0] p, input logic [31:0] e,
                                     input logic [1:0] c, input logic v,
                                     input logic [15:0] n);
      snap_t x;
      x.pc    = p;
      x.epc   = e;
      x.cause = c;
      x.valid = v;
      x.cnt   = n;
      return x;
   endfunction

   function automatic snap_t observe();
      return mk_snap(pc, epc, exc_cause, pc_valid, load_cnt);
   endfunction

   task automatic apply(input stim_t s);
      {pc_write, pc_write_cond, cond, exc_req, exc_ack} = s.ctl;
      pc_sel = s.sel;
   endtask

   task automatic set_srcs();
      for (int i = 0; i < N_SRC; i++) begin
         src_bus[i*DATA_W +: DATA_W] = 32'(32'h100 * (i + 1));
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reset values, then BOOT swallowing a pc_write on its edge.
   task automatic test_reset();
      snap_t obs, e;
      reset_n = 1'b0;
      set_srcs();
      apply(mk_stim(5'b10000, 3'd0));
      #22;
      for (int ph = 0; ph < 4; ph++) begin
         if (ph == 1) begin
            @(negedge clk);
            reset_n = 1'b1;
            #1;
         end else if (ph == 2) begin
            step();
         end else if (ph == 3) begin
            apply(mk_stim(5'b00000, 3'd0));
            step();
         end
         if (ph < 2) exp_q.push_back(mk_snap(32'h0, 32'h0, 2'd0, 1'b0, 16'h0));
         else        exp_q.push_back(mk_snap(32'h0, 32'h0, 2'd0, 1'b1, 16'h0));
         obs = observe();
         e   = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL reset[%0d] got pc=%h epc=%h cause=%0d valid=%0b cnt=%h, expected pc=%h epc=%h cause=%0d valid=%0b cnt=%h",
                     ph, obs.pc, obs.epc, obs.cause, obs.valid, obs.cnt, e.pc, e.epc, e.cause, e.valid, e.cnt);
         end
      end
   endtask

   // Back-to-back unconditional loads across every legal source, then hold.
   task automatic test_sweep();
      stim_t st[7];
      snap_t ex[7];
      snap_t obs, e;
      for (int i = 0; i < 6; i++) begin
         st[i] = mk_stim(5'b10000, 3'(i));
         ex[i] = mk_snap(32'(32'h100 * (i + 1)), 32'h0, 2'd0, 1'b1, 16'(i + 1));
      end
      st[6] = mk_stim(5'b00000, 3'd1);
      ex[6] = mk_snap(32'h600, 32'h0, 2'd0, 1'b1, 16'd6);
      for (int i = 0; i < 7; i++) begin
         apply(st[i]);
         exp_q.push_back(ex[i]);
         step();
         obs = observe();
         e   = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL sweep[%0d] got pc=%h epc=%h cause=%0d valid=%0b cnt=%h, expected pc=%h epc=%h cause=%0d valid=%0b cnt=%h",
                     i, obs.pc, obs.epc, obs.cause, obs.valid, obs.cnt, e.pc, e.epc, e.cause, e.valid, e.cnt);
         end
      end
   endtask

   // Conditional loads: not-taken, taken, combined with pc_write, bare cond.
   task automatic test_cond_branch();
      stim_t st[4];
      snap_t ex[4];
      snap_t obs, e;
      st[0] = mk_stim(5'b01000, 3'd2); ex[0] = mk_snap(32'h600, 32'h0, 2'd0, 1'b1, 16'd6);
      st[1] = mk_stim(5'b01100, 3'd2); ex[1] = mk_snap(32'h300, 32'h0, 2'd0, 1'b1, 16'd7);
      st[2] = mk_stim(5'b11100, 3'd3); ex[2] = mk_snap(32'h400, 32'h0, 2'd0, 1'b1, 16'd8);
      st[3] = mk_stim(5'b00100, 3'd1); ex[3] = mk_snap(32'h400, 32'h0, 2'd0, 1'b1, 16'd8);
      for (int i = 0; i < 4; i++) begin
         apply(st[i]);
         exp_q.push_back(ex[i]);
         step();
         obs = observe();
         e   = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL cond[%0d] got pc=%h epc=%h cause=%0d valid=%0b cnt=%h, expected pc=%h epc=%h cause=%0d valid=%0b cnt=%h",
                     i, obs.pc, obs.epc, obs.cause, obs.valid, obs.cnt, e.pc, e.epc, e.cause, e.valid, e.cnt);
         end
      end
   endtask

   // External exception beats a same-cycle load; TRAP ignores requests;
   // ack with pc_write returns with a new PC; ack in RUN does nothing.
   task automatic test_exception();
      stim_t st[5];
      snap_t ex[5];
      snap_t obs, e;
      st[0] = mk_stim(5'b10010, 3'd1); ex[0] = mk_snap(32'hFC,  32'h400, 2'd1, 1'b0, 16'd8);
      st[1] = mk_stim(5'b10010, 3'd1); ex[1] = mk_snap(32'hFC,  32'h400, 2'd1, 1'b0, 16'd8);
      st[2] = mk_stim(5'b01100, 3'd2); ex[2] = mk_snap(32'hFC,  32'h400, 2'd1, 1'b0, 16'd8);
      st[3] = mk_stim(5'b10001, 3'd3); ex[3] = mk_snap(32'h400, 32'h400, 2'd0, 1'b1, 16'd9);
      st[4] = mk_stim(5'b00001, 3'd0); ex[4] = mk_snap(32'h400, 32'h400, 2'd0, 1'b1, 16'd9);
      for (int i = 0; i < 5; i++) begin
         apply(st[i]);
         exp_q.push_back(ex[i]);
         step();
         obs = observe();
         e   = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL exception[%0d] got pc=%h epc=%h cause=%0d valid=%0b cnt=%h, expected pc=%h epc=%h cause=%0d valid=%0b cnt=%h",
                     i, obs.pc, obs.epc, obs.cause, obs.valid, obs.cnt, e.pc, e.epc, e.cause, e.valid, e.cnt);
         end
      end
   endtask

   // Illegal select and misaligned targets, both from RUN and on ack.
   task automatic test_illegal_misaligned();
      stim_t st[7];
      snap_t ex[7];
      snap_t obs, e;
      src_bus[5*DATA_W +: DATA_W] = 32'h202;
      st[0] = mk_stim(5'b10000, 3'd7); ex[0] = mk_snap(32'hFC, 32'h400, 2'd3, 1'b0, 16'd9);
      st[1] = mk_stim(5'b10001, 3'd6); ex[1] = mk_snap(32'hFC, 32'h400, 2'd3, 1'b0, 16'd9);
      st[2] = mk_stim(5'b10001, 3'd5); ex[2] = mk_snap(32'hFC, 32'h400, 2'd2, 1'b0, 16'd9);
      st[3] = mk_stim(5'b00001, 3'd0); ex[3] = mk_snap(32'hFC, 32'h400, 2'd0, 1'b1, 16'd9);
      st[4] = mk_stim(5'b10000, 3'd5); ex[4] = mk_snap(32'hFC, 32'hFC,  2'd2, 1'b0, 16'd9);
      st[5] = mk_stim(5'b00001, 3'd0); ex[5] = mk_snap(32'hFC, 32'hFC,  2'd0, 1'b1, 16'd9);
      st[6] = mk_stim(5'b01000, 3'd5); ex[6] = mk_snap(32'hFC, 32'hFC,  2'd0, 1'b1, 16'd9);
      for (int i = 0; i < 7; i++) begin
         apply(st[i]);
         exp_q.push_back(ex[i]);
         step();
         obs = observe();
         e   = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL illegal[%0d] got pc=%h epc=%h cause=%0d valid=%0b cnt=%h, expected pc=%h epc=%h cause=%0d valid=%0b cnt=%h",
                     i, obs.pc, obs.epc, obs.cause, obs.valid, obs.cnt, e.pc, e.epc, e.cause, e.valid, e.cnt);
         end
      end
      set_srcs();
   endtask

   // load_cnt wrap: 9 loads so far, 65525 more reach 0xFFFE; check the last two.
   task automatic test_wrap();
      snap_t obs, e;
      apply(mk_stim(5'b10000, 3'd0));
      repeat (65525) step();
      for (int i = 0; i < 2; i++) begin
         if (i == 0) exp_q.push_back(mk_snap(32'h100, 32'hFC, 2'd0, 1'b1, 16'hFFFF));
         else        exp_q.push_back(mk_snap(32'h100, 32'hFC, 2'd0, 1'b1, 16'h0000));
         step();
         obs = observe();
         e   = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL wrap[%0d] got pc=%h epc=%h cause=%0d valid=%0b cnt=%h, expected pc=%h epc=%h cause=%0d valid=%0b cnt=%h",
                     i, obs.pc, obs.epc, obs.cause, obs.valid, obs.cnt, e.pc, e.epc, e.cause, e.valid, e.cnt);
         end
      end
   endtask

   // Enter TRAP, then pull reset between clock edges and reboot.
   task automatic test_reset_mid_trap();
      snap_t obs, e;
      for (int ph = 0; ph < 3; ph++) begin
         if (ph == 0) begin
            apply(mk_stim(5'b00010, 3'd0));
            exp_q.push_back(mk_snap(32'hFC, 32'h100, 2'd1, 1'b0, 16'h0));
            step();
         end else if (ph == 1) begin
            apply(mk_stim(5'b00000, 3'd0));
            exp_q.push_back(mk_snap(32'h0, 32'h0, 2'd0, 1'b0, 16'h0));
            #2;
            reset_n = 1'b0;
            #1;
         end else begin
            repeat (2) @(negedge clk);
            reset_n = 1'b1;
            exp_q.push_back(mk_snap(32'h0, 32'h0, 2'd0, 1'b1, 16'h0));
            step();
         end
         obs = observe();
         e   = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL reset_mid_trap[%0d] got pc=%h epc=%h cause=%0d valid=%0b cnt=%h, expected pc=%h epc=%h cause=%0d valid=%0b cnt=%h",
                     ph, obs.pc, obs.epc, obs.cause, obs.valid, obs.cnt, e.pc, e.epc, e.cause, e.valid, e.cnt);
         end
      end
   endtask

   initial begin
      test_reset();
      test_sweep();
      test_cond_branch();
      test_exception();
      test_illegal_misaligned();
      test_wrap();
      test_reset_mid_trap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
